// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Package     : core_pkg
// Description : Shared constants for the MEM stage: bus widths, one-hot
//               load-type bit indices and EXE->MEM bus field offsets.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

  localparam int ES_TO_MS_BUS_WD = 76;
  localparam int MS_TO_WS_BUS_WD = 70;
  localparam int MS_FWD_BUS_WD   = 38;

  // One-hot load type {ld_b, ld_bu, ld_h, ld_hu, ld_w}
  localparam int LD_TYPE_WD = 5;
  localparam int LD_B       = 4;
  localparam int LD_BU      = 3;
  localparam int LD_H       = 2;
  localparam int LD_HU      = 1;
  localparam int LD_W       = 0;

  // es_to_ms_bus = {ld_type[4:0], res_from_mem, gr_we, dest[4:0], result[31:0], pc[31:0]}
  localparam int ES_PC_LSB           = 0;
  localparam int ES_RESULT_LSB       = 32;
  localparam int ES_DEST_LSB         = 64;
  localparam int ES_GR_WE_BIT        = 69;
  localparam int ES_RES_FROM_MEM_BIT = 70;
  localparam int ES_LD_TYPE_LSB      = 71;

endpackage
`default_nettype wire

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
// Interface   : mem_stage_if
// Description : Handshake and bus signals around the MEM stage.
//   ws_allowin      WB can accept this cycle
//   ms_allowin      MEM can accept from EXE
//   es_to_ms_valid  EXE presents a valid instruction
//   es_to_ms_bus    EXE->MEM payload
//   data_sram_rdata synchronous data-SRAM read data
//   ms_to_ws_valid  valid instruction to WB
//   ms_to_ws_bus    {gr_we, dest, final_result, pc}
//   ms_fwd_bus      {fwd_we, dest, final_result} for ID forwarding
//   in_ms_valid     MEM occupancy, for ID hazard logic
//   Modport slave is the MEM stage; master is its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_if;

  logic                                 ws_allowin;
  logic                                 ms_allowin;
  logic                                 es_to_ms_valid;
  logic [core_pkg::ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic [31:0]                          data_sram_rdata;
  logic                                 ms_to_ws_valid;
  logic [core_pkg::MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic [core_pkg::MS_FWD_BUS_WD-1:0]   ms_fwd_bus;
  logic                                 in_ms_valid;

  modport slave (
    input  ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_rdata,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus, in_ms_valid
  );

  modport master (
    output ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_rdata,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus, in_ms_valid
  );

endinterface
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_load_align
// Description : Combinational load aligner. Selects the byte/halfword named
//               by the low address bits and sign- or zero-extends it.
//   ld_type    one-hot {ld_b, ld_bu, ld_h, ld_hu, ld_w}; zero -> raw word
//   addr       result[1:0] of the load address
//   rdata      32-bit read word
//   load_data  aligned, extended result
// Revision    : 1.0 - initial release
// ============================================================================
module mem_load_align
  import core_pkg::*;
(
  input  logic [LD_TYPE_WD-1:0] ld_type,
  input  logic [1:0]            addr,
  input  logic [31:0]           rdata,
  output logic [31:0]           load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte    = rdata[{addr, 3'b000} +: 8];
    // Halfword alignment is guaranteed by the ISA, so only addr[1] matters.
    w_half    = addr[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    if (ld_type[LD_B]) begin
      load_data = {{24{w_byte[7]}}, w_byte};
    end else if (ld_type[LD_BU]) begin
      load_data = {24'h0, w_byte};
    end else if (ld_type[LD_H]) begin
      load_data = {{16{w_half[15]}}, w_half};
    end else if (ld_type[LD_HU]) begin
      load_data = {16'h0, w_half};
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : MEM pipeline stage. Latches the EXE->MEM bus under the
//               valid/allowin handshake, captures the first-cycle SRAM read
//               data (buffered across WB stalls), aligns load results and
//               forwards {gr_we, dest, final_result, pc} to WB.
//   clk    clock, all state on posedge
//   reset  synchronous, active-high
//   ms_if  mem_stage_if.slave (handshake, buses, SRAM read data)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  ms_if
);

  localparam logic c_ms_ready_go = 1'b1;

  logic                       r_ms_valid;
  logic                       r_first;
  logic                       r_rbuf_vld;
  logic [31:0]                r_rbuf;
  logic [ES_TO_MS_BUS_WD-1:0] r_bus;

  logic                       w_ms_allowin;
  logic [LD_TYPE_WD-1:0]      w_ld_type;
  logic                       w_res_from_mem;
  logic                       w_gr_we;
  logic [4:0]                 w_dest;
  logic [31:0]                w_result;
  logic [31:0]                w_pc;
  logic [31:0]                w_eff_rdata;
  logic [31:0]                w_load_data;
  logic [31:0]                w_final_result;

  assign w_ms_allowin   = !r_ms_valid || (c_ms_ready_go && ms_if.ws_allowin);

  assign w_ld_type      = r_bus[ES_LD_TYPE_LSB +: LD_TYPE_WD];
  assign w_res_from_mem = r_bus[ES_RES_FROM_MEM_BIT];
  assign w_gr_we        = r_bus[ES_GR_WE_BIT];
  assign w_dest         = r_bus[ES_DEST_LSB +: 5];
  assign w_result       = r_bus[ES_RESULT_LSB +: 32];
  assign w_pc           = r_bus[ES_PC_LSB +: 32];

  // The SRAM only holds its data during the first MEM cycle; afterwards the
  // buffered copy stands in for however long WB stalls.
  assign w_eff_rdata    = r_first    ? ms_if.data_sram_rdata :
                          r_rbuf_vld ? r_rbuf : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ms_valid <= 1'b0;
      r_first    <= 1'b0;
      r_rbuf_vld <= 1'b0;
      r_rbuf     <= 32'h0;
      r_bus      <= '0;
    end else begin
      if (w_ms_allowin) begin
        r_ms_valid <= ms_if.es_to_ms_valid;
      end
      // Capture unconditionally in the first cycle, even if WB accepts now.
      if (r_first) begin
        r_rbuf     <= ms_if.data_sram_rdata;
        r_rbuf_vld <= 1'b1;
      end
      // A newly latched instruction invalidates the previous buffer;
      // placed last so it wins over the capture above.
      if (ms_if.es_to_ms_valid && w_ms_allowin) begin
        r_bus      <= ms_if.es_to_ms_bus;
        r_first    <= 1'b1;
        r_rbuf_vld <= 1'b0;
      end else begin
        r_first    <= 1'b0;
      end
    end
  end

  mem_load_align u_load_align (
    .ld_type   (w_ld_type),
    .addr      (w_result[1:0]),
    .rdata     (w_eff_rdata),
    .load_data (w_load_data)
  );

  assign w_final_result       = w_res_from_mem ? w_load_data : w_result;

  assign ms_if.ms_allowin     = w_ms_allowin;
  assign ms_if.ms_to_ws_valid = r_ms_valid && c_ms_ready_go;
  assign ms_if.in_ms_valid    = r_ms_valid;
  assign ms_if.ms_to_ws_bus   = {w_gr_we, w_dest, w_final_result, w_pc};
  assign ms_if.ms_fwd_bus     = {r_ms_valid && w_gr_we, w_dest, w_final_result};

endmodule
`default_nettype wire
